// File: rtl/i2s_stereo_transmitter.sv
// I2S / left-justified stereo serializer with a free-running frame position counter.
// Optional build macro I2S_TX_HOLD_LAST_EN: repeat the last accepted pair on underrun.
module i2s_stereo_transmitter #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 16,
  parameter int MODE     = 0
) (
  input  logic                serial_clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                word_select,
  output logic                sound_bit_out,
  output logic                frame_start,
  output logic                underrun
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int PW    = $clog2(FRAME);

  localparam logic [PW-1:0] P_LAST  = PW'(FRAME - 1);
  localparam logic [PW-1:0] P_SLOT  = PW'(SLOT_W);
  localparam logic [PW-1:0] P_WS_LO = PW'(SLOT_W - 1);
  localparam logic [PW-1:0] P_WS_HI = PW'(FRAME - 2);

  logic [PW-1:0]       p;
  logic [PW-1:0]       p_next;
  logic [SAMPLE_W-1:0] cur_l, cur_r;
  logic [SAMPLE_W-1:0] next_l, next_r;
  logic [SAMPLE_W-1:0] fill_l, fill_r;
  logic                ws_next;
  logic                bit_next;

  // Left-justified bit for frame position pos, given the frame's sample pair.
  function automatic logic bit_at(input logic [PW-1:0]       pos,
                                  input logic [SAMPLE_W-1:0] l,
                                  input logic [SAMPLE_W-1:0] r);
    int         pi;
    logic [31:0] lx, rx;
    logic [4:0]  idx;
    pi     = 32'(pos);
    lx     = 32'(l);
    rx     = 32'(r);
    idx    = '0;
    bit_at = 1'b0;
    if (pi < SAMPLE_W) begin
      idx    = 5'(SAMPLE_W - 1 - pi);
      bit_at = lx[idx];
    end else if (pi >= SLOT_W && pi < SLOT_W + SAMPLE_W) begin
      idx    = 5'(SAMPLE_W - 1 - (pi - SLOT_W));
      bit_at = rx[idx];
    end
  endfunction

  // Handshake: sample_ready is high only in the last cycle of a frame; a pair is
  // taken on the edge where sample_ready && sample_valid, otherwise valid is ignored.
  assign sample_ready = (p == P_LAST);

`ifdef I2S_TX_HOLD_LAST_EN
  assign fill_l = cur_l;
  assign fill_r = cur_r;
`else
  assign fill_l = '0;
  assign fill_r = '0;
`endif

  always_comb begin
    p_next = sample_ready ? '0 : p + 1'b1;
    next_l = cur_l;
    next_r = cur_r;
    if (sample_ready) begin
      next_l = sample_valid ? left_in  : fill_l;
      next_r = sample_valid ? right_in : fill_r;
    end
    if (MODE == 1) begin
      ws_next  = (p_next >= P_SLOT);
      bit_next = bit_at(p_next, next_l, next_r);
    end else begin
      // I2S trails by one position, so it replays the old position with the old pair.
      ws_next  = (p_next >= P_WS_LO) && (p_next <= P_WS_HI);
      bit_next = bit_at(p, cur_l, cur_r);
    end
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      p             <= P_LAST;
      cur_l         <= '0;
      cur_r         <= '0;
      word_select   <= 1'b0;
      sound_bit_out <= 1'b0;
      frame_start   <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      p             <= p_next;
      cur_l         <= next_l;
      cur_r         <= next_r;
      word_select   <= ws_next;
      sound_bit_out <= bit_next;
      frame_start   <= sample_ready;
      underrun      <= sample_ready & ~sample_valid;
    end
  end

endmodule

// File: doc/i2s_stereo_transmitter.md
I2S_STEREO_TRANSMITTER -- requirements
Module: i2s_stereo_transmitter

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: bits per channel sample; legal range 8..32.
REQ-002 SHALL have parameter SLOT_W, default 16: serial_clk cycles per channel slot; legal range SAMPLE_W..32.
REQ-003 SHALL have parameter MODE, default 0: 0 = I2S (data one cycle behind word_select), 1 = left-justified.
REQ-004 SHALL have port serial_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port left_in, input, SAMPLE_W: left sample, two's complement.
REQ-007 SHALL have port right_in, input, SAMPLE_W: right sample, two's complement.
REQ-008 SHALL have port sample_valid, input, 1: left_in/right_in pair is valid.
REQ-009 SHALL have port sample_ready, output, 1: block accepts a pair this cycle.
REQ-010 SHALL have port word_select, output, 1: 0 = left slot, 1 = right slot.
REQ-011 SHALL have port sound_bit_out, output, 1: serial data, MSB first.
REQ-012 SHALL have port frame_start, output, 1: one-cycle pulse at frame position 0.
REQ-013 SHALL have port underrun, output, 1: one-cycle pulse when a frame starts without a new pair.

Function
REQ-014 SHALL keep a position counter p, width $clog2(2*SLOT_W); increments each edge; wraps 2*SLOT_W-1 -> 0.
REQ-015 SHALL register all outputs except sample_ready; each registered output reflects the new p at that edge.
REQ-016 SHALL drive sample_ready combinationally high only while p == 2*SLOT_W-1: one cycle per frame.
REQ-017 SHALL capture left_in/right_in at an edge where sample_ready and sample_valid are both 1; pair transmits in the frame starting at that edge.
REQ-018 SHALL ignore sample_valid whenever sample_ready is 0.
REQ-019 SHALL, for MODE=1, drive word_select = 1 for p in [SLOT_W, 2*SLOT_W-1], else 0.
REQ-020 SHALL, for MODE=1, drive left bit SAMPLE_W-1-p at p < SAMPLE_W, right bit SAMPLE_W-1-(p-SLOT_W) at SLOT_W <= p < SLOT_W+SAMPLE_W, else 0.
REQ-021 SHALL, for MODE=0, drive word_select = 1 for p in [SLOT_W-1, 2*SLOT_W-2], else 0.
REQ-022 SHALL, for MODE=0, drive at position p the bit MODE=1 drives at (p-1) mod 2*SLOT_W.
REQ-023 SHALL, for MODE=0, take position-0 data from the previous frame, so the right LSB is transmitted when SAMPLE_W == SLOT_W.
REQ-024 SHALL give latency from capture edge to left MSB on sound_bit_out of 1 edge (MODE=1) or 2 edges (MODE=0).
REQ-025 SHALL pulse frame_start at every edge where p becomes 0.
REQ-026 SHALL pulse underrun, coincident with frame_start, when sample_valid was 0 at the capture edge.
REQ-027 SHALL transmit zeros for an underrun frame unless REQ-033 applies.
REQ-028 SHALL not affect frame timing or word_select on underrun.

Reset
REQ-029 SHALL, on reset low, set immediately: p = 2*SLOT_W-1; word_select, sound_bit_out, frame_start, underrun = 0; sample registers = 0.
REQ-030 SHALL drive sample_ready = 1 while in reset, from p = 2*SLOT_W-1.
REQ-031 SHALL, on mid-frame reset, discard captured and in-flight samples; no partial bits after release.
REQ-032 SHALL, after reset release, reach frame position 0 on the first edge; capture per REQ-017 applies at that edge.

Configuration
REQ-033 SHALL, with I2S_TX_HOLD_LAST_EN defined, retransmit the last accepted pair on underrun (zeros if none since reset); underrun still pulses.
REQ-034 SHALL, without I2S_TX_HOLD_LAST_EN, transmit zeros on underrun and hold no extra copy of the last pair.

Verification
REQ-035 SHALL cover: defaults, left=0xA5F0, right=0x0F0F, valid held -> ws rises p=15, falls p=31; bits p=1..16 = A5F0 MSB-first; p=17..31 = 0F0F[15:1]; next p=0 = 1.
REQ-036 SHALL cover: MODE=1, same data -> A5F0 at p=0..15, 0F0F at p=16..31; ws = 1 exactly p=16..31.
REQ-037 SHALL cover: SAMPLE_W=24, SLOT_W=32, MODE=0, left=0x800001 -> left bits at p=1..24, zeros p=25..32; sample_ready high once per 64 cycles.
REQ-038 SHALL cover: valid low for one frame after 0x1234/0x5678 -> underrun and frame_start pulse together; data zeros (without macro) or 0x1234/0x5678 (with macro).
REQ-039 SHALL cover: reset at p=20 -> outputs 0 at once; after release, frame_start on first edge; no stale bits.
